mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single-ported unified main memory between the instruction-cache fill path and the data-cache miss/write path of the 16-bit processor. Grants one requester at a time and issues the block-fill address burst or the single write-through word. Steers returning memory words into the granted cache with a word index, and reports completion.

## Interface
- BLOCK_WORDS, 8, 16-bit words per cache block; power of two, 2..16; block = 2*BLOCK_WORDS bytes, offset bits OB = log2(BLOCK_WORDS)+1
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  I-cache fill request, level, held until i_done
- i_addr  in  16  I-cache miss byte address; low OB bits ignored
- d_req  in  1  D-cache fill request, level, held until d_done
- d_wr  in  1  D-cache single-word write request, level, held until d_done
- d_addr  in  16  D-cache byte address (block address for fill, word address for write; bit 0 ignored)
- d_wdata  in  16  write data for d_wr
- mem_en  out  1  memory access strobe
- mem_wr  out  1  1 = write, 0 = read (valid with mem_en)
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_valid  in  1  mem_rdata valid; one pulse per read, in issue order
- fill_data  out  16  mem_rdata forwarded to caches
- fill_word  out  log2(BLOCK_WORDS)  word index of fill_data in block
- i_fill_we  out  1  write fill_data into I-cache line
- d_fill_we  out  1  write fill_data into D-cache line
- i_done  out  1  one-cycle completion pulse, I port
- d_done  out  1  one-cycle completion pulse, D port
- busy  out  1  state != IDLE

## Operation
- States: IDLE, I_FILL, D_FILL, D_WRITE.
- IDLE: pending I = i_req; pending D = d_req|d_wr. Only one pending -> grant it. Both -> grant the port not granted last (round robin); last_grant resets to I, so D wins the first tie. Grant latches base address (addr with low OB bits cleared; for write, addr with bit 0 cleared) and d_wdata. Updates last_grant. Next state: I_FILL, D_FILL, or D_WRITE.
- Within D port: d_wr has precedence over d_req. A still-high d_req is re-arbitrated after the write completes.
- FILL states:
  - Issue counter k runs 0..BLOCK_WORDS-1. Each cycle: mem_en=1, mem_wr=0, mem_addr = base | (k<<1). k saturates, and mem_en stops after BLOCK_WORDS issues.
  - Receive counter r counts mem_valid. Each mem_valid: fill_we of granted port = 1, fill_word = r, fill_data = mem_rdata.
  - On the mem_valid with r = BLOCK_WORDS-1, the port's done = 1 in the same cycle; next state IDLE.
  - mem_valid outside FILL states is ignored (no fill_we).
- D_WRITE: single cycle. mem_en=1, mem_wr=1, mem_addr and mem_wdata from latched values, d_done=1. Next state IDLE. No mem_valid is expected.
- Requests are sampled only in IDLE. Request drop mid-transaction is ignored; the transaction completes and done still pulses. A requester must deassert req in the cycle after its done, else a new transaction starts.
- mem_wdata = 0 and mem_addr = 0 when mem_en = 0.
- Reset: state IDLE, counters 0, last_grant = I. All outputs 0 from the first cycle after the reset edge. Reset mid-transaction abandons it with no done pulse. Memory shares rst, so in-flight reads are flushed and no stale mem_valid arrives.

## Timing
- Fill, request seen in IDLE at edge E0: mem_en high cycles 1..BLOCK_WORDS after E0. With memory latency L (mem_valid L cycles after issue), fill_we runs cycles 1+L..BLOCK_WORDS+L and done falls on the last of them; busy drops on the next cycle. L=4, BLOCK_WORDS=8: en cycles 1..8, fill_we cycles 5..12, done cycle 12, IDLE cycle 13.
- Write: request at E0 -> mem_en/mem_wr/d_done in cycle 1 -> IDLE in cycle 2.
- Minimum gap between transactions: one IDLE cycle.
- All control outputs are decoded from registered state/counters plus mem_valid; no combinational path from i_req/d_req/d_wr to memory outputs.

## Test plan
- Single I fill, i_addr=0x1236, L=4: mem_addr 0x1230,0x1232..0x123E in cycles 1..8; i_fill_we with fill_word 0..7 in cycles 5..12; i_done in cycle 12 only; d_fill_we never asserted.
- D write, d_addr=0x0040, d_wdata=0xBEEF: one cycle mem_en=1, mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF, d_done=1; busy for exactly 1 cycle.
- i_req and d_req raised together after reset, each re-raised after done: grant order D, I, D, I; fill_data for each block goes only to the granted port's we.
- d_wr and d_req both high: write completes first (d_done), then the D fill runs; i_req held throughout is granted after the write (round robin) and before the fill.
- i_req dropped at cycle 3 of a fill: all 8 words still written and i_done pulses; no new transaction follows.
- rst asserted at cycle 6 of a D fill: the next cycle has all outputs 0 and busy=0 with no d_done; a new i_req is then served normally starting from fill_word 0.

Source files
------------

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single-ported unified main memory between the I-cache fill path
// and the D-cache fill / write-through path. One requester is served at a
// time. A fill streams BLOCK_WORDS read addresses out back-to-back and steers
// the returning words into the granted cache with a word index. A write is
// a single memory cycle.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   i_req, i_addr         I-cache fill request (level) and miss byte address
//   d_req, d_wr           D-cache fill / single-word write requests (level)
//   d_addr, d_wdata       D-cache byte address and write data
//   mem_en, mem_wr        memory strobe and direction (1 = write)
//   mem_addr, mem_wdata   memory byte address and write data (0 when idle)
//   mem_rdata, mem_valid  read data return, one pulse per read, in order
//   fill_data, fill_word  returned word and its index within the block
//   i_fill_we, d_fill_we  cache line write enables for the granted port
//   i_done, d_done        one-cycle completion pulses
//   busy                  arbiter is not idle
//   o_dbg_state           current FSM state, for checkers and debug
//
// Handshake: a requester raises its request and holds it until its done
// pulse; requests are only looked at while idle, so a request that is still
// high in the cycle after done starts a new transaction. Dropping a request
// mid-transaction does not cancel it. Memory reads return mem_valid in issue
// order with any fixed latency; mem_valid outside a fill is ignored.
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int BLOCK_WORDS = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_req,
   input  logic [15:0]                    i_addr,
   input  logic                           d_req,
   input  logic                           d_wr,
   input  logic [15:0]                    d_addr,
   input  logic [15:0]                    d_wdata,
   output logic                           mem_en,
   output logic                           mem_wr,
   output logic [15:0]                    mem_addr,
   output logic [15:0]                    mem_wdata,
   input  logic [15:0]                    mem_rdata,
   input  logic                           mem_valid,
   output logic [15:0]                    fill_data,
   output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
   output logic                           i_fill_we,
   output logic                           d_fill_we,
   output logic                           i_done,
   output logic                           d_done,
   output logic                           busy,
   output logic [1:0]                     o_dbg_state
);

   // word index width and byte offset width within a block
   localparam int WB = $clog2(BLOCK_WORDS);
   localparam int OB = WB + 1;

   // clears the byte offset inside a block
   localparam logic [15:0] C_BLK_MASK = ~((16'd1 << OB) - 16'd1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_I_FILL  = 2'd1;
   localparam logic [1:0] S_D_FILL  = 2'd2;
   localparam logic [1:0] S_D_WRITE = 2'd3;

   logic [1:0]    r_state;
   logic          r_last_d;   // 1 = the most recent grant went to the D port
   logic [15:0]   r_base;     // block base (fill) or word address (write)
   logic [15:0]   r_wdata;
   logic [WB:0]   r_issue;    // read addresses issued; MSB set = all issued
   logic [WB-1:0] r_recv;     // words received so far

   logic          w_in_fill;
   logic          w_in_write;
   logic          w_issue;
   logic          w_recv;
   logic          w_last_word;
   logic          w_pend_i;
   logic          w_pend_d;
   logic          w_grant_d;
   logic          w_grant_i;
   logic [15:0]   w_issue_addr;

   // ---------------------------------------------------------------------------
   // Decode of registered state; only mem_valid/mem_rdata reach outputs
   // combinationally, the request inputs never do.
   // ---------------------------------------------------------------------------
   assign w_in_fill  = (r_state == S_I_FILL) || (r_state == S_D_FILL);
   assign w_in_write = (r_state == S_D_WRITE);

   // BLOCK_WORDS is a power of two, so the counter MSB flags "all issued"
   assign w_issue     = w_in_fill & ~r_issue[WB];
   assign w_recv      = w_in_fill & mem_valid;
   assign w_last_word = w_recv & (&r_recv);

   // base has its offset bits cleared, so OR-ing the word offset is an add
   assign w_issue_addr = r_base | {{(16-OB){1'b0}}, r_issue[WB-1:0], 1'b0};

   // Round robin: on a tie the port that was not served last wins.
   // r_last_d resets to 0 (I), so the D port wins the first tie.
   assign w_pend_i  = i_req;
   assign w_pend_d  = d_req | d_wr;
   assign w_grant_d = w_pend_d & (~w_pend_i | ~r_last_d);
   assign w_grant_i = w_pend_i & ~w_grant_d;

   assign mem_en    = w_issue | w_in_write;
   assign mem_wr    = w_in_write;
   assign mem_addr  = w_in_write ? r_base : (w_issue ? w_issue_addr : 16'd0);
   assign mem_wdata = w_in_write ? r_wdata : 16'd0;

   assign fill_data = w_recv ? mem_rdata : 16'd0;
   assign fill_word = w_recv ? r_recv : '0;
   assign i_fill_we = w_recv & (r_state == S_I_FILL);
   assign d_fill_we = w_recv & (r_state == S_D_FILL);

   // done rides on the last returned word, so the cache sees it together
   // with the final fill write
   assign i_done = w_last_word & (r_state == S_I_FILL);
   assign d_done = (w_last_word & (r_state == S_D_FILL)) | w_in_write;

   assign busy        = (r_state != S_IDLE);
   assign o_dbg_state = r_state;

   // ---------------------------------------------------------------------------
   // State and counters
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_last_d <= 1'b0;
         r_base   <= 16'd0;
         r_wdata  <= 16'd0;
         r_issue  <= '0;
         r_recv   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_issue <= '0;
               r_recv  <= '0;
               if (w_grant_d) begin
                  r_last_d <= 1'b1;
                  // a pending write goes ahead of a pending D fill; the
                  // fill is picked up on a later pass through idle
                  if (d_wr) begin
                     r_state <= S_D_WRITE;
                     r_base  <= {d_addr[15:1], 1'b0};
                     r_wdata <= d_wdata;
                  end else begin
                     r_state <= S_D_FILL;
                     r_base  <= d_addr & C_BLK_MASK;
                  end
               end else if (w_grant_i) begin
                  r_last_d <= 1'b0;
                  r_state  <= S_I_FILL;
                  r_base   <= i_addr & C_BLK_MASK;
               end
            end

            S_I_FILL, S_D_FILL: begin
               if (w_issue) begin
                  r_issue <= r_issue + 1'b1;
               end
               if (w_recv) begin
                  r_recv <= r_recv + 1'b1;
               end
               if (w_last_word) begin
                  r_state <= S_IDLE;
                  r_issue <= '0;
                  r_recv  <= '0;
               end
            end

            S_D_WRITE: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Drives mem_arbiter with directed and random requester traffic against a
// fixed-latency memory model. A transaction-level reference model predicts
// every output in every cycle from the elapsed time since each grant and the
// memory latency; completions are also checked in order against a queue of
// expected grants.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int BW = 8;

   // ---------------------------------------------------------------------------
   // clock / reset and DUT signals
   // ---------------------------------------------------------------------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0;
   logic [15:0] i_addr = 16'd0;
   logic        d_req = 1'b0;
   logic        d_wr = 1'b0;
   logic [15:0] d_addr = 16'd0;
   logic [15:0] d_wdata = 16'd0;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = 16'd0;
   logic        mem_valid = 1'b0;
   logic [15:0] fill_data;
   logic [2:0]  fill_word;
   logic        i_fill_we;
   logic        d_fill_we;
   logic        i_done;
   logic        d_done;
   logic        busy;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   mem_arbiter #(.BLOCK_WORDS(BW)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_req       (i_req),
      .i_addr      (i_addr),
      .d_req       (d_req),
      .d_wr        (d_wr),
      .d_addr      (d_addr),
      .d_wdata     (d_wdata),
      .mem_en      (mem_en),
      .mem_wr      (mem_wr),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_valid   (mem_valid),
      .fill_data   (fill_data),
      .fill_word   (fill_word),
      .i_fill_we   (i_fill_we),
      .d_fill_we   (d_fill_we),
      .i_done      (i_done),
      .d_done      (d_done),
      .busy        (busy),
      .o_dbg_state (dbg_state)
   );

   // ---------------------------------------------------------------------------
   // checking
   // ---------------------------------------------------------------------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
      end
   endtask

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return (a * 16'h9E37) ^ 16'h5A5A;
   endfunction

   // ---------------------------------------------------------------------------
   // reference model: what is being served and how long since it was granted
   // ---------------------------------------------------------------------------
   bit          m_busy = 1'b0;
   bit          m_write = 1'b0;
   bit          m_port_d = 1'b0;
   bit          m_last_d = 1'b0;
   int          m_t = 0;
   logic [15:0] m_base = 16'd0;
   logic [15:0] m_wdata = 16'd0;
   bit          chk_en = 1'b0;
   int          mem_lat = 4;
   logic [0:0]  exp_q[$];          // expected completion order, 1 = D port

   bit          ev_i_done = 1'b0;  // expected done of the last checked cycle
   bit          ev_d_done = 1'b0;

   // memory staging, captured mid-cycle and applied after the next edge
   bit          stg_vld = 1'b0;
   bit          stg_rst = 1'b1;
   logic [15:0] stg_addr = 16'd0;
   bit          pipe_v [16];
   logic [15:0] pipe_a [16];

   logic        e_en, e_wr, e_recv, e_ifwe, e_dfwe, e_idone, e_ddone, e_busy;
   logic [15:0] e_addr, e_wdata, e_fdata;
   logic [2:0]  e_word;
   logic [0:0]  e_port;
   int          w_idx;
   bit          take_d, p_i, p_d;

   always @(negedge clk) begin
      // expected outputs for the current cycle
      e_busy  = m_busy;
      e_en    = m_busy && (m_write || m_t <= BW);
      e_wr    = m_busy && m_write;
      e_addr  = !e_en ? 16'd0 : (m_write ? m_base : m_base + 16'(2 * (m_t - 1)));
      e_wdata = e_wr ? m_wdata : 16'd0;
      e_recv  = m_busy && !m_write && (m_t > mem_lat) && (m_t <= BW + mem_lat);
      w_idx   = m_t - 1 - mem_lat;
      e_word  = e_recv ? 3'(w_idx) : 3'd0;
      e_fdata = e_recv ? mem_word(m_base + 16'(2 * w_idx)) : 16'd0;
      e_ifwe  = e_recv && !m_port_d;
      e_dfwe  = e_recv && m_port_d;
      e_idone = m_busy && !m_write && !m_port_d && (m_t == BW + mem_lat);
      e_ddone = m_busy && (m_write || (m_port_d && m_t == BW + mem_lat));

      if (chk_en) begin
         check("mem",  {30'd0, mem_en, mem_wr, mem_addr, mem_wdata},
                       {30'd0, e_en, e_wr, e_addr, e_wdata});
         check("fill", {43'd0, i_fill_we, d_fill_we, fill_word, fill_data},
                       {43'd0, e_ifwe, e_dfwe, e_word, e_fdata});
         check("ctl",  {60'd0, i_done, d_done, busy, (dbg_state != 2'd0)},
                       {60'd0, e_idone, e_ddone, e_busy, e_busy});
         if (i_done || d_done) begin
            if (exp_q.size() == 0) begin
               check("done_extra", {62'd0, i_done, d_done}, 64'd0);
            end else begin
               e_port = exp_q.pop_front();
               check("done_order", {62'd0, i_done, d_done},
                     {62'd0, ~e_port[0], e_port[0]});
            end
         end
      end
      ev_i_done = e_idone;
      ev_d_done = e_ddone;

      // memory sees this cycle's request at the coming edge
      stg_vld  = mem_en && !mem_wr;
      stg_addr = mem_addr;
      stg_rst  = rst;

      // advance the model across the coming edge
      if (rst) begin
         m_busy   = 1'b0;
         m_t      = 0;
         m_last_d = 1'b0;
         chk_en   = 1'b1;
         exp_q.delete();
      end else if (m_busy) begin
         if (m_write || m_t == BW + mem_lat) m_busy = 1'b0;
         else m_t++;
      end else begin
         p_i = i_req;
         p_d = d_req || d_wr;
         if (p_i || p_d) begin
            take_d   = p_d && (!p_i || !m_last_d);
            m_busy   = 1'b1;
            m_t      = 1;
            m_last_d = take_d;
            m_port_d = take_d;
            if (take_d) begin
               m_write = d_wr;
               m_base  = d_wr ? (d_addr & 16'hFFFE) : (d_addr & 16'hFFF0);
               m_wdata = d_wdata;
            end else begin
               m_write = 1'b0;
               m_base  = i_addr & 16'hFFF0;
            end
            exp_q.push_back(take_d);
         end
      end
   end

   // fixed-latency memory; shares rst, so a reset flushes in-flight reads.
   // Stray mem_valid pulses are injected whenever no fill is in progress.
   always @(posedge clk) begin
      #1;
      if (stg_rst) begin
         for (int i = 0; i < 16; i++) pipe_v[i] = 1'b0;
      end else begin
         for (int i = 15; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_a[i] = pipe_a[i-1];
         end
         pipe_v[0] = stg_vld;
         pipe_a[0] = stg_addr;
      end
      if (pipe_v[mem_lat-1]) begin
         mem_valid = 1'b1;
         mem_rdata = mem_word(pipe_a[mem_lat-1]);
      end else if (m_busy && !m_write) begin
         mem_valid = 1'b0;
         mem_rdata = 16'($urandom);
      end else begin
         mem_valid = ($urandom_range(0, 3) == 0);
         mem_rdata = 16'($urandom);
      end
   end

   // ---------------------------------------------------------------------------
   // driver tasks (called and returning just after a rising edge)
   // ---------------------------------------------------------------------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input bit port_d, input string tag);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 300) begin
         @(posedge clk);
         n++;
         seen = port_d ? ev_d_done : ev_i_done;
      end
      check(tag, {63'd0, seen}, 64'd1);
      #1;
   endtask

   task automatic txn_i(input logic [15:0] a);
      i_addr = a;
      i_req  = 1'b1;
      wait_done(1'b0, "i_timeout");
      i_req  = 1'b0;
   endtask

   // kind: 0 = write, 1 = fill, 2 = write and fill requested together
   task automatic txn_d(input int kind, input logic [15:0] a, input logic [15:0] wd);
      d_addr  = a;
      d_wdata = wd;
      d_wr    = (kind != 1);
      d_req   = (kind != 0);
      wait_done(1'b1, "d_timeout");
      d_wr    = 1'b0;
      if (kind == 2) begin
         d_addr = a ^ 16'h0100;
         wait_done(1'b1, "d_timeout");
      end
      d_req   = 1'b0;
   endtask

   task automatic agent_i(input int n);
      for (int k = 0; k < n; k++) begin
         idle($urandom_range(1, 4));
         txn_i(16'($urandom));
      end
   endtask

   task automatic agent_d(input int n);
      for (int k = 0; k < n; k++) begin
         idle($urandom_range(1, 4));
         txn_d($urandom_range(0, 2), 16'($urandom), 16'($urandom));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // stimulus
   // ---------------------------------------------------------------------------
   initial begin
      mem_lat = 4;
      idle(3);
      rst = 1'b0;
      idle(2);

      // simultaneous I and D fills, each re-raised after its done: D,I,D,I
      fork
         begin
            txn_d(1, 16'h2000, 16'h0000);
            idle(1);
            txn_d(1, 16'h2050, 16'h0000);
         end
         begin
            txn_i(16'h3000);
            idle(1);
            txn_i(16'h30A2);
         end
      join
      idle(3);

      // write and fill together on D, I held: write, then I, then D fill
      fork
         txn_d(2, 16'h0A12, 16'h1357);
         txn_i(16'h4444);
      join
      idle(3);

      // lone write, then lone I fill from the canonical example
      txn_d(0, 16'h0040, 16'hBEEF);
      idle(3);
      txn_i(16'h1236);
      idle(3);

      // I request dropped in cycle 3 of its fill
      i_addr = 16'h5678;
      i_req  = 1'b1;
      idle(3);
      i_req  = 1'b0;
      wait_done(1'b0, "i_timeout");
      idle(10);

      // reset in cycle 6 of a D fill, then a normal I fill
      d_addr = 16'h7777;
      d_req  = 1'b1;
      idle(6);
      rst    = 1'b1;
      d_req  = 1'b0;
      idle(1);
      rst    = 1'b0;
      idle(2);
      txn_i(16'h6543);
      idle(3);

      // random traffic at several memory latencies
      for (int ph = 0; ph < 5; ph++) begin
         mem_lat = $urandom_range(1, 6);
         idle(2);
         fork
            agent_i(6);
            agent_d(6);
         join
         idle(4);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
